// File: rtl/sdram_pro_arbit.sv
// sdram_pro_arbit: SDRAM command-bus arbiter (init, refresh, write, read); refresh wins, write/read round-robin; ports: sys_clk/sys_rst, per-engine req/end/cmd/addr/ba, *_en grants, sdram_* pins
module sdram_pro_arbit #(
  parameter int DQ_W   = 16,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BA_W-1:0]   init_ba,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [BA_W-1:0]   aref_ba,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe
);
  localparam logic [3:0] NO_OPERATION = 4'b0111;
  typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;
  state_t state, nxt;
  logic last_wr, end_armed, sel_end, done;
  logic [3:0] cmd;
  always_comb begin
    sel_end = state == AREF ? aref_end : state == WRITE ? wr_end : state == READ ? rd_end : 1'b0;
    done = end_armed && sel_end;
    nxt = state;
    case (state)
      INIT:    nxt = init_end ? ARBIT : INIT;
      ARBIT:   nxt = aref_req ? AREF : (wr_req && rd_req) ? (last_wr ? READ : WRITE) :
                     wr_req ? WRITE : rd_req ? READ : ARBIT;
      default: nxt = done ? ARBIT : state;
    endcase
  end
  // engines hold *_end high until re-enabled, so an end only counts after it was seen low in this grant
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= INIT;
      last_wr   <= 1'b0;
      end_armed <= 1'b0;
    end else begin
      state     <= nxt;
      end_armed <= (state == INIT || state == ARBIT) ? 1'b0 : (end_armed || !sel_end);
      if (done && state == WRITE) last_wr <= 1'b1;
      if (done && state == READ) last_wr <= 1'b0;
    end
  end
  assign aref_en = state == AREF;
  assign wr_en   = state == WRITE;
  assign rd_en   = state == READ;
  assign cmd = state == INIT ? init_cmd : state == AREF ? aref_cmd : state == WRITE ? wr_cmd :
               state == READ ? rd_cmd : NO_OPERATION;
  assign sdram_addr = state == INIT ? init_addr : state == AREF ? aref_addr : state == WRITE ? wr_addr :
                      state == READ ? rd_addr : '1;
  assign sdram_ba = state == INIT ? init_ba : state == AREF ? aref_ba : state == WRITE ? wr_ba :
                    state == READ ? rd_ba : '1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke    = 1'b1;
  assign sdram_dq_out = wr_sdram_data;
  assign sdram_dq_oe  = state == WRITE && wr_sdram_en;
endmodule

// File: tb/tb_sdram_pro_arbit.sv
// tb_sdram_pro_arbit: table-driven, directed and random checks of sdram_pro_arbit against a reference model
module tb_sdram_pro_arbit;
  localparam int O_INIT = 10, O_IDLE = 11, O_AREF = 12, O_WR = 13, O_RD = 14;
  logic clk = 0, sys_rst = 1, init_end = 0;
  logic [3:0] init_cmd = 4'h1, aref_cmd = 4'h2, wr_cmd = 4'h3, rd_cmd = 4'h4;
  logic [11:0] init_addr = 12'h111, aref_addr = 12'h222, wr_addr = 12'h333, rd_addr = 12'h444;
  logic [1:0] init_ba = 2'd0, aref_ba = 2'd1, wr_ba = 2'd2, rd_ba = 2'd3;
  logic aref_req = 0, aref_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
  logic wr_sdram_en = 1;
  logic [15:0] wr_sdram_data = 16'hbeef;
  logic aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dq_oe;
  logic [1:0] sdram_ba;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  int errors = 0, checks = 0;
  int m_owner = O_INIT;
  bit m_low_seen = 0;
  int served[$];

  sdram_pro_arbit dut (
    .sys_clk(clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .aref_ba(aref_ba), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .rd_en(rd_en), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, ie, ar, wr, rd, ae, we, re;
    int sel;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cmd_of(input int o);
    return o == O_INIT ? init_cmd : o == O_AREF ? aref_cmd : o == O_WR ? wr_cmd :
           o == O_RD ? rd_cmd : 4'b0111;
  endfunction

  function automatic logic [11:0] addr_of(input int o);
    return o == O_INIT ? init_addr : o == O_AREF ? aref_addr : o == O_WR ? wr_addr :
           o == O_RD ? rd_addr : 12'hfff;
  endfunction

  function automatic logic [1:0] ba_of(input int o);
    return o == O_INIT ? init_ba : o == O_AREF ? aref_ba : o == O_WR ? wr_ba :
           o == O_RD ? rd_ba : 2'b11;
  endfunction

  function automatic logic [2:0] en_of(input int o);
    return {o == O_AREF, o == O_WR, o == O_RD};
  endfunction

  // reference: owner of the bus, whether its end was seen low since grant, and the order of completed W/R grants
  task automatic tick();
    int n_owner = m_owner;
    bit n_low = m_low_seen;
    bit end_now;
    if (sys_rst) begin
      n_owner = O_INIT;
      n_low = 0;
      served.delete();
    end else if (m_owner == O_INIT) begin
      if (init_end) n_owner = O_IDLE;
    end else if (m_owner == O_IDLE) begin
      n_low = 0;
      if (aref_req) n_owner = O_AREF;
      else if (wr_req && rd_req) n_owner = (served.size() > 0 && served[$] == O_WR) ? O_RD : O_WR;
      else if (wr_req) n_owner = O_WR;
      else if (rd_req) n_owner = O_RD;
    end else begin
      end_now = m_owner == O_AREF ? aref_end : m_owner == O_WR ? wr_end : rd_end;
      if (m_low_seen && end_now) begin
        n_owner = O_IDLE;
        if (m_owner != O_AREF) served.push_back(m_owner);
      end else if (!end_now) n_low = 1;
    end
    @(posedge clk);
    m_owner = n_owner;
    m_low_seen = n_low;
    #1;
  endtask

  task automatic check_model();
    chk("cmd", {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, cmd_of(m_owner)});
    chk("addr", {20'd0, sdram_addr}, {20'd0, addr_of(m_owner)});
    chk("ba", {30'd0, sdram_ba}, {30'd0, ba_of(m_owner)});
    chk("en", {29'd0, aref_en, wr_en, rd_en}, {29'd0, en_of(m_owner)});
    chk("dq_oe", {31'd0, sdram_dq_oe}, {31'd0, m_owner == O_WR && wr_sdram_en});
    chk("dq_out", {16'd0, sdram_dq_out}, {16'd0, wr_sdram_data});
    chk("cke", {31'd0, sdram_cke}, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0,0, O_INIT};
    tbl[1]  = '{0,0,0,0,0,0,0,0, O_INIT};
    tbl[2]  = '{0,1,0,0,0,0,0,0, O_IDLE};
    tbl[3]  = '{0,0,0,0,0,0,0,0, O_IDLE};
    tbl[4]  = '{0,0,1,1,1,1,1,1, O_AREF};
    tbl[5]  = '{0,0,1,1,1,0,1,1, O_AREF};
    tbl[6]  = '{0,0,1,1,1,1,1,1, O_IDLE};
    tbl[7]  = '{0,0,0,1,1,1,1,1, O_WR};
    tbl[8]  = '{0,0,0,1,1,1,1,1, O_WR};
    tbl[9]  = '{0,0,0,1,1,1,1,1, O_WR};
    tbl[10] = '{0,0,0,1,1,1,0,1, O_WR};
    tbl[11] = '{0,0,0,1,1,1,1,1, O_IDLE};
    tbl[12] = '{0,0,0,1,1,1,1,1, O_RD};
    tbl[13] = '{0,0,0,1,1,1,1,0, O_RD};
    tbl[14] = '{0,0,0,1,1,1,1,1, O_IDLE};
    tbl[15] = '{0,0,0,1,1,1,1,1, O_WR};
    tbl[16] = '{0,0,1,1,1,1,0,1, O_WR};
    tbl[17] = '{0,0,1,1,1,1,1,1, O_IDLE};
    tbl[18] = '{0,0,1,0,1,1,1,1, O_AREF};
    tbl[19] = '{0,0,0,0,1,0,1,1, O_AREF};
    tbl[20] = '{0,0,0,0,1,1,1,1, O_IDLE};
    tbl[21] = '{0,0,0,0,1,1,1,1, O_RD};
    tbl[22] = '{1,0,0,0,1,1,1,1, O_INIT};
    tbl[23] = '{0,0,0,0,1,1,1,1, O_INIT};
    for (int i = 0; i < 24; i++) begin
      {sys_rst, init_end, aref_req, wr_req, rd_req} = {tbl[i].rst, tbl[i].ie, tbl[i].ar, tbl[i].wr, tbl[i].rd};
      {aref_end, wr_end, rd_end} = {tbl[i].ae, tbl[i].we, tbl[i].re};
      tick();
      chk($sformatf("tbl%0d_cmd", i), {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
          {28'd0, cmd_of(tbl[i].sel)});
      chk($sformatf("tbl%0d_en", i), {29'd0, aref_en, wr_en, rd_en}, {29'd0, en_of(tbl[i].sel)});
      chk($sformatf("tbl%0d_oe", i), {31'd0, sdram_dq_oe}, {31'd0, tbl[i].sel == O_WR});
      check_model();
    end
    // init_end first seen at the 10th cycle after reset
    sys_rst = 1;
    {init_end, aref_req, wr_req, rd_req} = 4'b0;
    tick();
    sys_rst = 0;
    for (int c = 1; c <= 10; c++) begin
      init_end = c == 10;
      tick();
      chk($sformatf("init_c%0d", c), {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
          c == 10 ? 32'h7 : {28'd0, init_cmd});
      check_model();
    end
    chk("idle_addr", {20'd0, sdram_addr}, 32'hfff);
    chk("idle_ba", {30'd0, sdram_ba}, 32'h3);
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sys_rst = $urandom_range(0, 99) == 0;
      init_end = $urandom_range(0, 7) == 0;
      aref_req = $urandom_range(0, 5) == 0;
      wr_req = $urandom_range(0, 2) == 0;
      rd_req = $urandom_range(0, 2) == 0;
      {aref_end, wr_end, rd_end} = 3'($urandom);
      {init_cmd, aref_cmd, wr_cmd, rd_cmd} = 16'($urandom);
      {init_addr, aref_addr} = 24'($urandom);
      {wr_addr, rd_addr} = 24'($urandom);
      {init_ba, aref_ba, wr_ba, rd_ba} = 8'($urandom);
      wr_sdram_en = 1'($urandom);
      wr_sdram_data = 16'($urandom);
      tick();
      check_model();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_pro_arbit.md
# sdram_pro_arbit

SDRAM command-bus arbiter. It sits between the init, auto-refresh, write (`sdram_pro_write`) and read engines and the SDRAM pins. It grants the single command/address/data bus to one engine at a time, with auto-refresh always winning and write/read alternating round-robin. While an engine is granted, its registered command, address, bank and data are muxed through to the pins.

## Interface
Parameters:
- `DQ_W`, 16, SDRAM data width
- `ADDR_W`, 12, SDRAM address width
- `BA_W`, 2, bank address width

Ports:
- `sys_clk` in 1: single clock; everything is registered on its rising edge.
- `sys_rst` in 1: reset, synchronous and active-high.
- `init_end` in 1: initialisation done.
- `init_cmd` in 4, `init_addr` in ADDR_W, `init_ba` in BA_W: bus from the init engine.
- `aref_req` in 1, `aref_end` in 1, `aref_cmd` in 4, `aref_addr` in ADDR_W, `aref_ba` in BA_W: refresh engine.
- `aref_en` out 1: refresh grant (level).
- `wr_req` in 1, `wr_end` in 1, `wr_cmd` in 4, `wr_addr` in ADDR_W, `wr_ba` in BA_W: write engine.
- `wr_sdram_en` in 1, `wr_sdram_data` in DQ_W: write engine data path.
- `wr_en` out 1: write grant (level).
- `rd_req` in 1, `rd_end` in 1, `rd_cmd` in 4, `rd_addr` in ADDR_W, `rd_ba` in BA_W: read engine.
- `rd_en` out 1: read grant (level).
- `sdram_cke` out 1: constant 1.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: bits [3:0] of the selected command.
- `sdram_ba` out BA_W, `sdram_addr` out ADDR_W: selected bank and address.
- `sdram_dq_out` out DQ_W: equals `wr_sdram_data`.
- `sdram_dq_oe` out 1: `wr_sdram_en` while in WRITE, else 0.

## Operation
- **States:** INIT, ARBIT, AREF, WRITE, READ. The state is registered. Pin outputs and `*_en` are combinational decodes of the state only; there is no added latency on the engines' registered signals.
- **INIT:** mux the init bus. Go to ARBIT on the first cycle `init_end`=1. After that, `init_end` is never re-examined.
- **ARBIT:** drive `NO_OPERATION` (from `defines.v`), addr all-ones, ba all-ones. Grant order:
  - `aref_req` goes to AREF.
  - Otherwise, if both `wr_req` and `rd_req` are set, grant the one not served last (flag `last_wr`, reset 0, so write wins first).
  - Otherwise, grant whichever single request is set.
  - With no request, stay in ARBIT.
- **AREF / WRITE / READ:**
  - Assert the matching `*_en` and mux that engine's cmd/addr/ba.
  - WRITE also drives `sdram_dq_oe` = `wr_sdram_en`.
  - Leave to ARBIT on an armed end.
- **End arming:** engines hold `*_end` high until re-enabled, so `*_end` can be stale-high for up to 2 cycles after a grant.
  - A per-grant `end_armed` flag is cleared on entry to AREF/WRITE/READ.
  - It sets on the first cycle the granted engine's `*_end`=0.
  - Exit happens only when `end_armed`=1 and `*_end`=1.
- **`last_wr`:** set on exit from WRITE, cleared on exit from READ, unchanged by AREF.
- **Requests during a grant:** held by the requesters and not latched. `aref_req` never pre-empts a grant in progress.
- **Ignored inputs:** `*_end` of non-granted engines.

## Timing
- **Reset:**
  - The state goes to INIT on the edge where `sys_rst`=1; that edge also clears `last_wr` and `end_armed`.
  - During and just after reset, the outputs are `aref_en`=`wr_en`=`rd_en`=0, `sdram_cke`=1, pins = init bus, `sdram_dq_oe`=0.
- **Reset mid-grant:** `*_en` drops the cycle after the reset edge. The bus returns to the init engine.
- **Grant latency:** a request seen in ARBIT at cycle N puts `*_en` high at cycle N+1.
- **Release:**
  - An armed end seen at cycle M puts the state in ARBIT at M+1.
  - The earliest next grant is at M+2, giving at least one NOP cycle between owners.
- **Stale end:** `*_end`=1 continuously from grant entry does not exit until it has been 0 for at least one cycle and then returns to 1.
- **Simultaneous `aref_req`, `wr_req`, `rd_req` in ARBIT:** AREF is granted. On return, the write/read tie-break applies.

## Test plan
- **Init then idle:**
  - `init_end` rises at cycle 10 → pins follow `init_cmd` through cycle 10.
  - State is ARBIT at 11; cmd = `NO_OPERATION`, addr=12'hfff, ba=2'b11.
- **Write grant:**
  - `wr_req`=1 in ARBIT → `wr_en`=1 next cycle.
  - `wr_cmd`/`wr_addr`/`wr_ba` appear on the pins unchanged.
  - `sdram_dq_oe` tracks `wr_sdram_en` and `sdram_dq_out`=`wr_sdram_data`.
  - `wr_end` high-low-high → `wr_en`=0 one cycle after the second rise.
- **Stale end:** `wr_end` held 1 for the first 2 cycles of a grant → no release. Release only after `wr_end` has gone 0→1.
- **All three requests at once:**
  - AREF is granted first, then WRITE, then READ (round-robin).
  - Repeat with `wr_req`/`rd_req` both held → grants alternate W,R,W,R.
- **Refresh during a write:** `aref_req` raised mid-WRITE → `wr_en` stays 1 until the armed `wr_end`, then `aref_en`=1 two cycles later.
- **Mid-read reset:** `sys_rst`=1 during READ → next cycle `rd_en`=0, pins = init bus, `sdram_dq_oe`=0.
